// File: rtl/rom_fetch_ctrl_if.sv
// Bus bundle between the CPU-side requester, the fetch controller and the ROM.
// The master side issues requests, consumes responses and supplies ROM data.
interface rom_fetch_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_word;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_word,
    output req_signed,
    output resp_ready,
    output rom_data,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  rom_addr
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_word,
    input  req_signed,
    input  resp_ready,
    input  rom_data,
    output req_ready,
    output resp_valid,
    output resp_data,
    output rom_addr
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Byte/word fetch controller in front of a ROM with a fixed read pipeline.
// Words are assembled little-endian from two consecutive byte reads.
module rom_fetch_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  rom_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_HI,
    WAIT,
    RESP
  } state_t;

  localparam int CW = $clog2(LATENCY + 3);
  localparam logic [CW-1:0] LO_AT = CW'(LATENCY + 1);
  localparam logic [CW-1:0] HI_AT = CW'(LATENCY + 2);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [15:0]   addr_q;
  logic          word_q;
  logic          sign_q;
  logic [7:0]    lo_q;
  logic          rdy_q;

  logic          accept;
  logic          cap_lo;
  logic          cap_hi;
  logic          done;
  logic          resp_hs;
  logic [15:0]   data_nxt;

  // rdy_q keeps req_ready low until the first edge after reset release
  assign bus.req_ready = rdy_q && (state == IDLE);

  always_comb begin
    accept   = bus.req_valid && bus.req_ready;
    cap_lo   = (state == WAIT) && (cnt == LO_AT);
    cap_hi   = (state == WAIT) && word_q && (cnt == HI_AT);
    done     = cap_hi || (cap_lo && !word_q);
    resp_hs  = (state == RESP) && bus.resp_valid && bus.resp_ready;
    data_nxt = {{8{sign_q & bus.rom_data[7]}}, bus.rom_data};
    if (word_q) begin
      data_nxt = {bus.rom_data, lo_q};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bus.req_word ? ISSUE_HI : WAIT;
        end
      end
      ISSUE_HI: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
    end
  end

  // cnt counts edges since acceptance; clearing it on reset drops any
  // bytes still travelling through the ROM pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      addr_q <= 16'h0000;
      word_q <= 1'b0;
      sign_q <= 1'b0;
      lo_q   <= 8'h00;
    end else begin
      if (accept) begin
        cnt    <= CW'(1);
        addr_q <= bus.req_addr;
        word_q <= bus.req_word;
        sign_q <= bus.req_signed;
      end else if (state == ISSUE_HI || state == WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (cap_lo) begin
        lo_q <= bus.rom_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rom_addr <= 16'h0000;
    end else if (accept) begin
      bus.rom_addr <= bus.req_addr;
    end else if (state == ISSUE_HI) begin
      bus.rom_addr <= addr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= 16'h0000;
    end else begin
      if (done) begin
        bus.resp_valid <= 1'b1;
        bus.resp_data  <= data_nxt;
      end else if (resp_hs) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: ROM model, directed requests and a response
// scoreboard drained by an independent monitor.
module tb_rom_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if bus ();

  rom_fetch_ctrl #(.LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // two registers behind the registered address: LATENCY = 2
  logic [7:0] mem [0:65535];
  logic [7:0] pipe1;
  always @(posedge clk) begin
    pipe1        <= mem[bus.rom_addr];
    bus.rom_data <= pipe1;
  end

  int pass_cnt = 0;
  int total    = 0;
  logic [15:0] sb [$];

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (!reset && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got %h expected none", bus.resp_data);
      end else begin
        e = sb.pop_front();
        check("resp_data", bus.resp_data, e);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic w, input logic s,
                       input logic [15:0] exp);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      total++;
      $display("FAIL req_ready_timeout: got %b expected 1", bus.req_ready);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_word   = w;
    bus.req_signed = s;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sb.push_back(exp);
    check("rom_addr_lo", bus.rom_addr, a);
    check("req_ready_busy", {15'd0, bus.req_ready}, 16'd0);
    if (w) begin
      @(posedge clk);
      #1;
      check("rom_addr_hi", bus.rom_addr, a + 16'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("valid_early", {15'd0, bus.resp_valid}, 16'd0);
    @(posedge clk);
    #1;
    check("valid_rise", {15'd0, bus.resp_valid}, 16'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_word   = 1'b0;
    bus.req_signed = 1'b0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hAB;
    mem[16'h0020] = 8'h9C;
    mem[16'h2000] = 8'h34;
    mem[16'h2001] = 8'h12;
    mem[16'hFFFF] = 8'hCD;
    mem[16'h0000] = 8'hEF;
    mem[16'h0300] = 8'hC3;
    mem[16'h0400] = 8'h11;
    mem[16'h3000] = 8'h77;
    mem[16'h3001] = 8'h66;

    #2;
    check("rst_req_ready", {15'd0, bus.req_ready}, 16'd0);
    check("rst_resp_valid", {15'd0, bus.resp_valid}, 16'd0);
    check("rst_resp_data", bus.resp_data, 16'h0000);
    check("rst_rom_addr", bus.rom_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {15'd0, bus.req_ready}, 16'd1);

    issue(16'h1234, 1'b0, 1'b0, 16'h00AB);
    drain();
    mem[16'h0010] = 8'h80;
    issue(16'h0010, 1'b0, 1'b1, 16'hFF80);
    drain();
    mem[16'h0010] = 8'h7F;
    issue(16'h0010, 1'b0, 1'b1, 16'h007F);
    drain();
    issue(16'h0020, 1'b0, 1'b0, 16'h009C);
    drain();
    issue(16'h2000, 1'b1, 1'b0, 16'h1234);
    drain();
    issue(16'hFFFF, 1'b1, 1'b1, 16'hEFCD);
    drain();

    // back-pressure with a competing request held on the bus
    bus.resp_ready = 1'b0;
    issue(16'h0300, 1'b0, 1'b1, 16'hFFC3);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 16'h0400;
    bus.req_word   = 1'b0;
    bus.req_signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", bus.resp_data, 16'hFFC3);
      check("bp_valid", {15'd0, bus.resp_valid}, 16'd1);
      check("bp_req_ready", {15'd0, bus.req_ready}, 16'd0);
      check("bp_rom_addr", bus.rom_addr, 16'h0300);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_valid_low", {15'd0, bus.resp_valid}, 16'd0);
    check("hs_req_ready", {15'd0, bus.req_ready}, 16'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sb.push_back(16'h0011);
    check("bp_next_addr", bus.rom_addr, 16'h0400);
    drain();

    // reset between E1 and E2 of a word read
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 16'h3000;
    bus.req_word   = 1'b1;
    bus.req_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rom_hi", bus.rom_addr, 16'h3001);
    reset = 1'b1;
    #1;
    check("abort_req_ready", {15'd0, bus.req_ready}, 16'd0);
    check("abort_valid", {15'd0, bus.resp_valid}, 16'd0);
    check("abort_data", bus.resp_data, 16'h0000);
    check("abort_rom_addr", bus.rom_addr, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    mem[16'h0005] = 8'h5A;
    issue(16'h0005, 1'b0, 1'b0, 16'h005A);
    drain();

    repeat (4) @(negedge clk);
    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
# rom_fetch_ctrl

Request/response fetch controller that sits directly upstream of the system ROM. It accepts byte or 16-bit word read requests from the CPU-side bus and drives the ROM's registered address input. It tracks the ROM's fixed two-cycle read pipeline and assembles little-endian words from two byte reads. Each result is returned with a valid/ready handshake.

## Interface
- LATENCY, 2: cycles from rom_addr being valid at a clock edge to rom_data holding that address's byte; must match the ROM's pipeline depth.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; reset 0, 1 from the first edge after reset deasserts.
- req_addr  in  16  byte address of the request.
- req_word  in  1  1 = 16-bit little-endian read of addr, addr+1; 0 = byte read.
- req_signed  in  1  byte reads only: 1 = sign-extend, 0 = zero-extend; ignored for words.
- resp_valid  out  1  response data valid; reset 0.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  16  response data; reset 16'h0000.
- rom_addr  out  16  registered address to the ROM; reset 16'h0000.
- rom_data  in  8  ROM read data.

## Operation
- States: IDLE, ISSUE_HI, WAIT, RESP; reset state IDLE.
- req_ready is 1 only in IDLE. It is 0 in all other states and while reset is asserted.
- IDLE: the request is accepted when req_valid && req_ready at an edge.
  - At that edge: rom_addr <= req_addr; word and signed flags are latched.
  - Next state is ISSUE_HI if req_word, else WAIT.
- ISSUE_HI: rom_addr <= latched addr + 1, modulo 2^16 (16'hFFFF + 1 = 16'h0000). Next state is WAIT.
- WAIT: a capture counter samples rom_data at fixed edges.
  - Low byte is sampled LATENCY+1 edges after acceptance.
  - High byte (word only) is sampled one edge later.
  - After the final byte is captured, next state is RESP.
- rom_addr holds its last value outside issue edges and is never driven speculatively.
- resp_data formation:
  - Word: {high byte, low byte}.
  - Byte: {8{b[7]} when signed, else 8'h00}, b.
- RESP: resp_valid = 1 and resp_data is held stable until resp_valid && resp_ready at an edge.
  - At that edge, resp_valid <= 0 and next state is IDLE.
  - req_ready rises in the cycle after the handshake; no request is accepted on the handshake edge.
- resp_ready is ignored outside RESP. req_valid and all req_* inputs are ignored outside IDLE.
- Reset mid-operation:
  - Everything returns to reset values asynchronously.
  - Bytes still in the ROM pipeline are discarded, because the capture counter is cleared.
  - The first request after reset sees no stale data.

## Timing
- Edge E0 is the edge at which a request is accepted.
- Byte read:
  - rom_addr = A during E0..E1.
  - Byte is captured at E3.
  - resp_valid = 1 from E3.
- Word read:
  - rom_addr = A during E0..E1 and A+1 during E1..E2.
  - Low byte is captured at E3, high byte at E4.
  - resp_valid = 1 from E4.
- General latency: byte LATENCY+1 edges after acceptance, word LATENCY+2 edges.
- With resp_ready held at 1, the handshake completes on the same edge resp_valid rises plus one: byte at E4, word at E5.
- With resp_ready held at 1, req_ready returns to 1 after that handshake edge.
- Minimum request spacing: byte 5 cycles, word 6 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs except req_ready, which is derived from state only.

## Test plan
- Byte, unsigned: ROM[16'h1234] = 8'hAB; request at E0 with A = 16'h1234, word = 0, signed = 0.
  - rom_addr = 16'h1234 after E0.
  - resp_valid rises at E3 with resp_data = 16'h00AB.
- Byte, signed: ROM[16'h0010] = 8'h80, signed = 1 -> resp_data = 16'hFF80.
- Byte, signed, positive: same setup with ROM[16'h0010] = 8'h7F -> resp_data = 16'h007F.
- Word, little-endian: ROM[16'h2000] = 8'h34, ROM[16'h2001] = 8'h12, word = 1.
  - rom_addr is 2000 then 2001 on consecutive cycles.
  - resp_valid at E4 with resp_data = 16'h1234.
- Word wrap-around: A = 16'hFFFF, ROM[16'hFFFF] = 8'hCD, ROM[16'h0000] = 8'hEF.
  - Second rom_addr = 16'h0000.
  - resp_data = 16'hEFCD.
- Back-pressure: resp_ready held low for 3 cycles after resp_valid rises, with req_valid = 1 carrying a different address throughout.
  - resp_data stays stable and req_ready stays 0; rom_addr is unchanged.
  - After the handshake, req_ready = 1 one cycle later and the new request is accepted.
- Reset mid-read: assert reset between E1 and E2 of a word read.
  - All outputs go to 0 immediately.
  - After release, a byte read of ROM[16'h0005] = 8'h5A returns 16'h005A with no residue from the aborted read.
